// File: rtl/pd_pkg.sv
// Shared definitions for the serial pattern detector.
//   pd_state_e : detector FSM state (still filling history / armed to match)
//   MODE_*     : values of mode_i selecting overlapping vs non-overlapping detection
package pd_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } pd_state_e;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_n : clock, async active-low reset (q -> 0)
//   inc          : count up by one, holding at all-ones
//   clr          : synchronous clear, wins over inc
//   q            : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with reloadable pattern.
//   clk_i, rst_n : clock, async active-low reset
//   en_i, a_i    : valid-qualified serial input bit
//   mode_i       : 1 = overlapping, 0 = non-overlapping detection
//   pat_load_i   : load pat_i as the new pattern (restarts history)
//   clr_i        : clear history, count and sticky flag
//   flag_o       : one-cycle match pulse, one cycle after the matching bit
//   sticky_o     : set on any match, held until clr_i / reset
//   count_o      : saturating match count
module pattern_detector
    import pd_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             a_i,
    input  logic             mode_i,
    input  logic             pat_load_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             clr_i,
    output logic             flag_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    pd_state_e         state_q, state_d;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic              flag_q;
    logic              sticky_q;

    logic              accept;
    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              arm_hit;
    logic              match;
    logic              restart;

    // Load and clear both discard the bit on the same cycle.
    assign accept     = en_i & ~clr_i & ~pat_load_i;
    assign hist_shift = {hist_q[PAT_W-2:0], a_i};
    assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    // The accepted bit leaves the history full: either already armed, or
    // this bit is the last one needed to fill it.
    assign arm_hit = (state_q == ST_ARMED) || (fill_q == FILL_LAST);
    assign match   = accept && arm_hit && (hist_shift == pat_q);

    // Non-overlapping match throws away the history so the next match needs
    // PAT_W fresh bits.
    assign restart = clr_i || pat_load_i || (match && (mode_i == MODE_NONOVL));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (accept && (fill_inc == FILL_FULL)) state_d = ST_ARMED;
                ST_ARMED: state_d = ST_ARMED;
                default:  state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            if (pat_load_i) pat_q <= pat_i;
            if (restart) begin
                hist_q <= '0;
                fill_q <= '0;
            end else if (accept) begin
                hist_q <= hist_shift;
                fill_q <= fill_inc;
            end
        end
    end

    // match is never set while clr_i is high, so flag drops on clear too.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            flag_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            flag_q <= match;
            if (clr_i)      sticky_q <= 1'b0;
            else if (match) sticky_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (clr_i),
        .q     (count_o)
    );

    assign flag_o   = flag_q;
    assign sticky_o = sticky_q;

endmodule
